// File: rtl/maj_chain_sequencer_if.sv
// ---------------------------------------------------------------------------
// maj_chain_sequencer_if
//   Bundles the operand-side handshake, the config-table write port and the
//   result-side handshake of maj_chain_sequencer.
//
//   in_valid / in_ready / in_data       : operand vector handshake
//   cfg_we / cfg_addr / cfg_wdata       : config table write strobe
//   cfg_err                             : one-cycle pulse, write rejected
//   out_valid / out_ready / out_data    : result handshake
//
//   master : the producer/consumer side (drives operands, configs, out_ready)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface maj_chain_sequencer_if #(
  parameter int STAGES = 7,
  parameter int CNT_W  = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2*STAGES:0]     in_data;
  logic                  cfg_we;
  logic [CNT_W-1:0]      cfg_addr;
  logic [3:0]            cfg_wdata;
  logic                  cfg_err;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_data;

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, out_ready,
    input  in_ready, cfg_err, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, out_ready,
    output in_ready, cfg_err, out_valid, out_data
  );
endinterface

// File: rtl/maj_chain_sequencer.sv
// ---------------------------------------------------------------------------
// maj_chain_sequencer
//   Evaluates a serial chain of STAGES MAJ3 gates with a single shared MAJ3
//   unit, one stage per clock. Each stage may invert any operand and force
//   its B operand to 1, controlled by a 4-bit entry of a config table.
//
//   Stage 0 operands : A=in_data[0], B=in_data[1], C=in_data[2]
//   Stage s>=1       : A=in_data[2s+1], B=in_data[2s+2], C=w[s-1]
//   cfg bits         : [0] invert A, [1] invert B, [2] invert C, [3] force B=1
//                      (force is applied before inversion)
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (also clears the config table)
//   bus        : maj_chain_sequencer_if.slave (operand / config / result)
//   trace_data : per-stage results of the last completed job
//                (present only when MAJ_TRACE_EN is defined)
//
// Optional feature macro: MAJ_TRACE_EN
// ---------------------------------------------------------------------------
module maj_chain_sequencer #(
  parameter int STAGES = 7,
  parameter int CNT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef MAJ_TRACE_EN
  maj_chain_sequencer_if.slave     bus,
  output logic [STAGES-1:0]        trace_data
`else
  maj_chain_sequencer_if.slave     bus
`endif
);

  localparam int OPW = 2*STAGES + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Force-B happens first, then the per-operand inversions.
  function automatic logic stage_eval(input logic a, input logic b,
                                      input logic c, input logic [3:0] cfg);
    logic b_f;
    b_f = cfg[3] ? 1'b1 : b;
    return maj3(a ^ cfg[0], b_f ^ cfg[1], c ^ cfg[2]);
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              cfg_err_q, cfg_err_d;
  logic [3:0]        cfg_q [STAGES];
  logic [OPW-1:0]    opnd_q;
  logic              carry_q;
  logic              load_op;

  logic              op_a, op_b, op_c;
  logic [3:0]        cfg_cur;
  logic              w;
  logic              cfg_addr_ok;
  logic              cfg_wr_ok;

  // Operand mux for the stage currently addressed by the counter.
  always_comb begin
    op_a    = 1'b0;
    op_b    = 1'b0;
    op_c    = 1'b0;
    cfg_cur = 4'b0000;
    for (int s = 0; s < STAGES; s++) begin
      if (cnt_q == CNT_W'(s)) begin
        if (s == 0) begin
          op_a = opnd_q[0];
          op_b = opnd_q[1];
          op_c = opnd_q[2];
        end else begin
          op_a = opnd_q[2*s+1];
          op_b = opnd_q[2*s+2];
          op_c = carry_q;
        end
        cfg_cur = cfg_q[s];
      end
    end
  end

  assign w = stage_eval(op_a, op_b, op_c, cfg_cur);

  // Writes are refused while a job is running so a job always sees one
  // consistent table; out-of-range addresses are refused too.
  assign cfg_addr_ok = (int'(bus.cfg_addr) < STAGES);
  assign cfg_wr_ok   = bus.cfg_we && (state_q != RUN) && cfg_addr_ok;
  assign cfg_err_d   = bus.cfg_we && !cfg_wr_ok;

  // Next-state / control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    load_op = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load_op = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STAGES-1)) begin
          cnt_d   = '0;
          out_d   = w;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Config table
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        cfg_q[s] <= 4'b0000;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (cfg_wr_ok && (bus.cfg_addr == CNT_W'(s))) begin
          cfg_q[s] <= bus.cfg_wdata;
        end
      end
    end
  end

  // Datapath: operand latch and chain carry
  always_ff @(posedge clk) begin
    if (load_op) begin
      opnd_q <= bus.in_data;
    end
    if (state_q == RUN) begin
      carry_q <= w;
    end
  end

`ifdef MAJ_TRACE_EN
  logic [STAGES-1:0] trace_q, trace_d;

  always_comb begin
    trace_d = trace_q;
    if (state_q == RUN) begin
      for (int s = 0; s < STAGES; s++) begin
        if (cnt_q == CNT_W'(s)) begin
          trace_d[s] = w;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_q <= '0;
    end else begin
      trace_q <= trace_d;
    end
  end

  assign trace_data = trace_q;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: doc/maj_chain_sequencer.md
Name: maj_chain_sequencer

Overview:
- Time-multiplexed evaluator for a serial majority-gate chain (MAJ3 stages, each fed by the previous stage result), using one shared MAJ3 unit, one stage per cycle.
- Per-stage operand inversion and constant forcing come from a programmable config table.
- Sits between an operand producer and a result consumer; valid/ready handshake on both sides.

Parameters:
- STAGES, 7, number of chained MAJ3 stages (>=2).
- CNT_W, 3, stage counter width; must satisfy 2**CNT_W >= STAGES.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  block can accept an operand vector.
- in_data  input  2*STAGES+1  operand bits.
- cfg_we  input  1  config table write strobe.
- cfg_addr  input  CNT_W  stage index to write.
- cfg_wdata  input  4  stage config: bit0 invert A, bit1 invert B, bit2 invert C, bit3 force B=1.
- cfg_err  output  1  one-cycle pulse: write rejected.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  1  final chain result.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, cfg_err=0, state=IDLE, stage counter=0, all config entries=4'b0000 (plain majority).
- Operands, stage 0: A=in_data[0], B=in_data[1], C=in_data[2].
- Operands, stage s>=1: A=in_data[2s+1], B=in_data[2s+2], C=w[s-1].
- Stage function, in this order:
  - if cfg[s][3], B=1;
  - then XOR each of A/B/C with its invert bit;
  - w[s] = MAJ(A,B,C) = AB|AC|BC.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_data into an operand register, clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, evaluate stage[counter] and register the result into the carry register.
  - After the stage STAGES-1 edge, go to DONE with out_data=w[STAGES-1].
- DONE:
  - out_valid=1, out_data held stable.
  - On out_ready, go to IDLE; out_valid drops next cycle.
- Latency: out_valid rises exactly STAGES clocks after the input-accept edge. Throughput is one result per STAGES+2 cycles when there is no backpressure.
- in_ready is 1 only in IDLE. No overlap of accept and deliver.
- Config writes:
  - Accepted in IDLE or DONE only.
  - Written value is visible to the next accepted job.
  - Write during RUN, or with cfg_addr>=STAGES: table unchanged, cfg_err=1 for one cycle.
- in_data changes after accept have no effect (operands latched).
- rst asserted mid-RUN or mid-DONE:
  - Aborts the job; all reset values are restored the next cycle, including the config table.
  - No out_valid is produced for the aborted job.
- out_ready low in DONE: hold indefinitely; no new input is accepted.

Optional Feature:
- Macro: MAJ_TRACE_EN.
- Defined:
  - Adds output port trace_data (width STAGES), where trace_data[s]=w[s] of the last completed job.
  - Valid whenever out_valid=1; reset value all zeros.
  - Bit s is captured in RUN at stage s.
- Undefined: port and capture register are absent; all other behaviour is identical.

Test Plan:
- Reset, cfg all 0, accept in_data=15'h7FFF -> out_valid rises 7 cycles after accept, out_data=1; with trace, trace_data=7'h7F.
- cfg all 0, in_data=15'h0007 -> w0=1, w1..w6=0, out_data=0; trace_data=7'h01.
- Write cfg[6]=4'b0011 in IDLE, in_data=15'h0000 -> out_data=1 (stage 6 A,B inverted); trace_data=7'h40.
- Write cfg[6]=4'b1000:
  - in_data=15'h2000 (bit13) -> out_data=1.
  - in_data=15'h0000 -> out_data=0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Negative and reset cases:
  - cfg_we during RUN -> cfg_err pulses once, result unchanged.
  - cfg_addr=7 -> cfg_err pulses.
  - rst at RUN stage 3 -> next cycle in_ready=1, out_valid=0, cfg table cleared.
